// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding and default frame geometry.
package uart_pkg;

  localparam int OVERSAMPLE_DEFAULT = 16;
  localparam int DATA_BITS_DEFAULT  = 8;

  typedef enum logic [2:0] {
    RX_IDLE   = 3'd0,
    RX_START  = 3'd1,
    RX_DATA   = 3'd2,
    RX_PARITY = 3'd3,
    RX_STOP   = 3'd4,
    RX_BREAK  = 3'd5
  } rx_state_t;

endpackage

// File: rtl/uart_receiver_if.sv
// RX queue side of the receiver: write strobe, byte and per-frame error pulses.
// There is no backpressure handshake: rx_queue_we is a one-clk write strobe,
// and rx_queue_full only decides whether the completed frame is written or dropped.
interface uart_receiver_if #(
  parameter int DATA_BITS = 8
) ();
  logic [DATA_BITS-1:0] rx_data;
  logic                 rx_queue_we;
  logic                 rx_queue_full;
  logic                 frame_err;
  logic                 parity_err;
  logic                 overrun_err;

  modport master (
    output rx_data, rx_queue_we, frame_err, parity_err, overrun_err,
    input  rx_queue_full
  );

  modport slave (
    input  rx_data, rx_queue_we, frame_err, parity_err, overrun_err,
    output rx_queue_full
  );
endinterface

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the asynchronous rxd pin; resets to the idle (high) level.
module uart_rx_sync (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);
  logic meta;

  always_ff @(posedge clk) begin
    if (reset) begin
      meta <= 1'b1;
      q    <= 1'b1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end
endmodule

// File: rtl/uart_receiver.sv
// UART receive controller: oversampled start detection, LSB-first data shift,
// optional parity and stop-bit check, one registered write/error pulse per frame.
module uart_receiver
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = DATA_BITS_DEFAULT,
  parameter int OVERSAMPLE = OVERSAMPLE_DEFAULT
) (
  input  logic      clk,
  input  logic      reset,
  input  logic      rx_clk_en,
  input  logic      rxd,
  input  logic      parity_en,
  input  logic      parity_odd,
  output logic      rx_busy,
  output rx_state_t state,
  uart_receiver_if.master q
);
  localparam int CW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS);
  localparam logic [CW-1:0] HALF = CW'(OVERSAMPLE / 2 - 1);
  localparam logic [CW-1:0] LAST = CW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(DATA_BITS - 1);

  logic rxd_s;

  uart_rx_sync u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (rxd),
    .q     (rxd_s)
  );

  rx_state_t            state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [BW-1:0]        bit_q, bit_d;
  logic [DATA_BITS-1:0] shreg_q, shreg_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 acc_q, acc_d;
  logic                 perr_q, perr_d;
  logic                 we_q, we_d;
  logic                 fe_q, fe_d;
  logic                 pe_q, pe_d;
  logic                 ov_q, ov_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= RX_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shreg_q <= '0;
      data_q  <= '0;
      acc_q   <= 1'b0;
      perr_q  <= 1'b0;
      we_q    <= 1'b0;
      fe_q    <= 1'b0;
      pe_q    <= 1'b0;
      ov_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shreg_q <= shreg_d;
      data_q  <= data_d;
      acc_q   <= acc_d;
      perr_q  <= perr_d;
      we_q    <= we_d;
      fe_q    <= fe_d;
      pe_q    <= pe_d;
      ov_q    <= ov_d;
    end
  end

  // Strobe next-values default to 0 so every pulse lasts exactly one clk.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shreg_d = shreg_q;
    data_d  = data_q;
    acc_d   = acc_q;
    perr_d  = perr_q;
    we_d    = 1'b0;
    fe_d    = 1'b0;
    pe_d    = 1'b0;
    ov_d    = 1'b0;

    if (rx_clk_en) begin
      case (state_q)
        RX_IDLE: begin
          if (!rxd_s) begin
            cnt_d   = '0;
            state_d = RX_START;
          end
        end
        RX_START: begin
          if (cnt_q == HALF) begin
            if (!rxd_s) begin
              cnt_d   = '0;
              bit_d   = '0;
              acc_d   = 1'b0;
              perr_d  = 1'b0;
              state_d = RX_DATA;
            end else begin
              state_d = RX_IDLE;
            end
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        RX_DATA: begin
          if (cnt_q == LAST) begin
            cnt_d   = '0;
            shreg_d = {rxd_s, shreg_q[DATA_BITS-1:1]};
            acc_d   = acc_q ^ rxd_s;
            bit_d   = bit_q + BW'(1);
            if (bit_q == BIT_LAST) state_d = parity_en ? RX_PARITY : RX_STOP;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        RX_PARITY: begin
          if (cnt_q == LAST) begin
            cnt_d   = '0;
            perr_d  = acc_q ^ rxd_s ^ parity_odd;
            state_d = RX_STOP;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        RX_STOP: begin
          if (cnt_q == LAST) begin
            cnt_d   = '0;
            data_d  = shreg_q;
            we_d    = !q.rx_queue_full;
            ov_d    = q.rx_queue_full;
            fe_d    = !rxd_s;
            pe_d    = parity_en & perr_q;
            state_d = rxd_s ? RX_IDLE : RX_BREAK;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        RX_BREAK: begin
          if (rxd_s) state_d = RX_IDLE;
        end
        default: state_d = RX_IDLE;
      endcase
    end
  end

  assign q.rx_data     = data_q;
  assign q.rx_queue_we = we_q;
  assign q.frame_err   = fe_q;
  assign q.parity_err  = pe_q;
  assign q.overrun_err = ov_q;
  assign rx_busy       = (state_q != RX_IDLE);
  assign state         = state_q;
endmodule

// File: tb/tb_uart_receiver.sv
// Directed bench for uart_receiver: frames driven bit by bit, each completed
// frame's strobes and flags compared against hand-computed expected entries.
module tb_uart_receiver;
  import uart_pkg::*;

  localparam int OS = 16;

  logic      clk = 1'b0;
  logic      reset;
  logic      rx_clk_en = 1'b0;
  logic      rxd;
  logic      parity_en;
  logic      parity_odd;
  logic      rx_busy;
  rx_state_t state;

  uart_receiver_if #(.DATA_BITS(8)) rif ();

  uart_receiver #(.DATA_BITS(8), .OVERSAMPLE(OS)) dut (
    .clk        (clk),
    .reset      (reset),
    .rx_clk_en  (rx_clk_en),
    .rxd        (rxd),
    .parity_en  (parity_en),
    .parity_odd (parity_odd),
    .rx_busy    (rx_busy),
    .state      (state),
    .q          (rif)
  );

  // clock/reset block: 10 ns clock, one tick every 4 clks
  always #5 clk = ~clk;

  int div = 0;
  always @(negedge clk) begin
    div       = (div + 1) % 4;
    rx_clk_en = (div == 0);
  end

  int n_checks = 0;
  int n_fail   = 0;

  // {overrun, frame_err, parity_err, we, data}
  logic [11:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic exp_push(input logic ov, input logic fe, input logic pe, input logic [7:0] d);
    exp_q.push_back({ov, fe, pe, ~ov, d});
  endtask

  // scoreboard: every strobe cycle must match the oldest expected frame
  always @(negedge clk) begin
    if (rif.rx_queue_we || rif.overrun_err || rif.frame_err || rif.parity_err) begin
      if (exp_q.size() == 0) begin
        check("spurious_strobe",
              {20'd0, rif.overrun_err, rif.frame_err, rif.parity_err, rif.rx_queue_we, rif.rx_data},
              32'd0);
      end else begin
        check("frame",
              {20'd0, rif.overrun_err, rif.frame_err, rif.parity_err, rif.rx_queue_we, rif.rx_data},
              {20'd0, exp_q.pop_front()});
      end
    end
  end

  // driver tasks
  task automatic wait_ticks(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      while (!rx_clk_en) @(posedge clk);
    end
  endtask

  task automatic send_bit(input logic b);
    #1 rxd = b;
    wait_ticks(OS);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic with_par,
                            input logic par_bit, input logic stop_val);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    if (with_par) send_bit(par_bit);
    send_bit(stop_val);
  endtask

  task automatic wait_drain(input string tag);
    int k = 0;
    while (exp_q.size() != 0 && k < 400) begin
      @(negedge clk);
      k++;
    end
    check(tag, exp_q.size(), 0);
  endtask

  initial begin
    reset             = 1'b1;
    rxd               = 1'b1;
    parity_en         = 1'b0;
    parity_odd        = 1'b0;
    rif.rx_queue_full = 1'b0;
    repeat (4) @(negedge clk);
    check("reset_busy",  rx_busy, 0);
    check("reset_state", state, RX_IDLE);
    check("reset_we",    rif.rx_queue_we, 0);
    check("reset_data",  rif.rx_data, 0);
    check("reset_errs",  {rif.frame_err, rif.parity_err, rif.overrun_err}, 0);
    reset = 1'b0;
    wait_ticks(4);

    // 8N1 0xA5
    exp_push(1'b0, 1'b0, 1'b0, 8'hA5);
    send_frame(8'hA5, 1'b0, 1'b0, 1'b1);
    wait_drain("a5_drain");
    check("a5_busy_after", rx_busy, 0);

    // parity: even 0x07 with bit 1 ok, bit 0 error; odd 0x07 with bit 0 ok
    parity_en = 1'b1;
    exp_push(1'b0, 1'b0, 1'b0, 8'h07);
    send_frame(8'h07, 1'b1, 1'b1, 1'b1);
    wait_drain("even_ok_drain");
    exp_push(1'b0, 1'b0, 1'b1, 8'h07);
    send_frame(8'h07, 1'b1, 1'b0, 1'b1);
    wait_drain("even_bad_drain");
    parity_odd = 1'b1;
    exp_push(1'b0, 1'b0, 1'b0, 8'h07);
    send_frame(8'h07, 1'b1, 1'b0, 1'b1);
    wait_drain("odd_ok_drain");
    parity_en  = 1'b0;
    parity_odd = 1'b0;
    wait_ticks(4);

    // 4-tick low glitch rejected, then 0x3C
    #1 rxd = 1'b0;
    wait_ticks(4);
    #1 rxd = 1'b1;
    wait_ticks(20);
    check("glitch_state", state, RX_IDLE);
    exp_push(1'b0, 1'b0, 1'b0, 8'h3C);
    send_frame(8'h3C, 1'b0, 1'b0, 1'b1);
    wait_drain("3c_drain");

    // 0x55 with low stop bit, line held low: break until line returns high
    exp_push(1'b0, 1'b1, 1'b0, 8'h55);
    send_frame(8'h55, 1'b0, 1'b0, 1'b0);
    wait_ticks(40);
    wait_drain("55_drain");
    check("break_state", state, RX_BREAK);
    check("break_busy", rx_busy, 1);
    send_bit(1'b1);
    check("break_exit", state, RX_IDLE);
    exp_push(1'b0, 1'b0, 1'b0, 8'h81);
    send_frame(8'h81, 1'b0, 1'b0, 1'b1);
    wait_drain("81_drain");

    // overrun on 0xFF, then back-to-back 0x12 written
    rif.rx_queue_full = 1'b1;
    exp_push(1'b1, 1'b0, 1'b0, 8'hFF);
    send_frame(8'hFF, 1'b0, 1'b0, 1'b1);
    rif.rx_queue_full = 1'b0;
    exp_push(1'b0, 1'b0, 1'b0, 8'h12);
    send_frame(8'h12, 1'b0, 1'b0, 1'b1);
    wait_drain("12_drain");

    // reset during bit 4 of 0x5A
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(((8'h5A >> i) & 8'h01) != 0);
    #1 rxd = 1'b1;
    wait_ticks(8);
    check("pre_reset_busy", rx_busy, 1);
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    check("midreset_state", state, RX_IDLE);
    check("midreset_busy",  rx_busy, 0);
    check("midreset_data",  rif.rx_data, 0);
    check("midreset_we",    rif.rx_queue_we, 0);
    reset = 1'b0;
    wait_ticks(20);
    exp_push(1'b0, 1'b0, 1'b0, 8'hC3);
    send_frame(8'hC3, 1'b0, 1'b0, 1'b1);
    wait_drain("c3_drain");
    check("final_busy", rx_busy, 0);

    wait_ticks(4);
    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end
endmodule
